dct_coef_mac: RTL and testbench
===============================

// Module: dct_coef_mac
// PURPOSE
//  Computes one 2-D DCT-II coefficient F(k1,k2) from one streamed NxN pixel block.
//  Basis terms are generated on the fly from a single 1-D cosine ROM, so one instance
//  serves any (k1,k2) at run time; this replaces the per-(k1,k2) fixed cosine LUTs.
//  Sits between the level-shifted pixel buffer and the coefficient quantiser.
// PARAMETERS
//  N      8   block edge, power of 2, 4..16; block holds N*N pixels
//  PIX_W  9   signed pixel width (level-shifted, -256..255)
//  FRAC   12  fractional bits of the cosine ROM and basis terms
//  OUT_W  32  signed coefficient output width
// PORTS
//  clk         in   1                   rising-edge clock
//  rst_n       in   1                   async active-low reset
//  start       in   1                   begin a block; k1/k2 are sampled in the same cycle
//  k1          in   $clog2(N)           vertical frequency index
//  k2          in   $clog2(N)           horizontal frequency index
//  busy        out  1                   high from accepted start until coefficient handed off
//  pix_valid   in   1                   pixel handshake valid
//  pix_ready   out  1                   pixel handshake ready
//  pix_data    in   PIX_W               signed pixel; raster order, n1 major, n2 minor
//  coef_valid  out  1                   result valid
//  coef_ready  in   1                   downstream accepts result
//  coef_data   out  OUT_W               signed F(k1,k2)
// BEHAVIOUR
//  - Reset: state=IDLE; busy, pix_ready, coef_valid = 0; coef_data = 0; accumulator and
//    indices cleared. Async assert, sync deassert.
//  - ROM: C[k][n] = rnd(a(k)*cos((2n+1)k*pi/(2N))*2^FRAC), with a(0)=sqrt(1/N) and
//    a(k>0)=sqrt(2/N). rnd = nearest, ties away from zero. Built as an elaboration-time
//    constant.
//  - Basis term: T = rnd(C[k1][n1]*C[k2][n2] / 2^FRAC), nearest, ties away from zero
//    (sign-symmetric, NOT a plain >>>).
//  - FSM IDLE -> RUN -> FLUSH -> DONE -> IDLE:
//    IDLE:  start=1 latches k1,k2, clears acc and n1,n2, busy=1, go RUN.
//    RUN:   pix_ready=1; each pix_valid&pix_ready adds pix_data*T(n1,n2) to acc; n2 counts,
//           wrapping to 0 and incrementing n1 at N-1; the N*N-th transfer goes to FLUSH.
//    FLUSH: one cycle, pix_ready=0; drains the MAC pipeline register.
//    DONE:  coef_valid=1; coef_data = sat_OUT_W(rnd(acc/2^FRAC)), held stable until
//           coef_ready; on handshake coef_valid=0, busy=0, go IDLE.
//  - Pipeline: product registered, accumulated next cycle. coef_valid rises exactly 2
//    cycles after the last pixel handshake.
//  - acc width >= PIX_W+2*FRAC+2*log2(N)+2; no internal overflow possible. Output
//    saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//  - pix_valid gaps stall the count; nothing is lost or double-counted.
//  - start is ignored unless IDLE. A start in the same cycle as the DONE handshake is
//    ignored.
//  - k1/k2 input changes after the latch cycle have no effect on the block in flight.
//  - pix_ready=0 outside RUN; pix_valid there is ignored.
//  - Reset mid-block aborts it with no output; the next start computes a clean result.
// TESTING
//  1 k=(0,0), 64 px of 100 (N=8,FRAC=12): C00=1448, T=512 -> coef_data=800, valid 2 cyc
//    after px 64.
//  2 k=(1,6), 64 px of 100 -> coef_data=0 exactly (antisymmetric terms).
//    Repeat for all 63 AC k pairs.
//  3 k=(1,6), impulse 255 at (n1=2,n2=5), else 0 -> coef_data=rnd(255*T(2,5)/4096),
//    matches real-number model within +/-1.
//  4 Random pixels, random pix_valid gaps, coef_ready held low 5 cycles ->
//    coef_valid/data stable, pix_ready=0, extra start ignored; result matches
//    bit-exact reference model.
//  5 rst_n low after 30 px -> next cycle busy=0, pix_ready=0, coef_valid=0;
//    new start with test 1 data -> 800.
//  6 start toggled while busy and k1/k2 changed mid-block -> result uses k latched at
//    the accepted start only.

Source files
------------

// File: rtl/dct_coef_mac_if.sv
// Block-level handshake bundle for dct_coef_mac: start/k control, pixel stream in, coefficient out.
// master drives start, pixels and coef_ready; slave is the MAC.
interface dct_coef_mac_if #(
  parameter int N     = 8,
  parameter int PIX_W = 9,
  parameter int OUT_W = 32
) ();
  logic                       start;
  logic [$clog2(N)-1:0]       k1;
  logic [$clog2(N)-1:0]       k2;
  logic                       busy;
  logic                       pix_valid;
  logic                       pix_ready;
  logic signed [PIX_W-1:0]    pix_data;
  logic                       coef_valid;
  logic                       coef_ready;
  logic signed [OUT_W-1:0]    coef_data;

  modport master (
    output start, k1, k2, pix_valid, pix_data, coef_ready,
    input  busy, pix_ready, coef_valid, coef_data
  );

  modport slave (
    input  start, k1, k2, pix_valid, pix_data, coef_ready,
    output busy, pix_ready, coef_valid, coef_data
  );
endinterface

// File: rtl/dct_coef_mac.sv
// One 2-D DCT-II coefficient per streamed NxN block; basis built from a 1-D cosine ROM.
// coef_valid 2 cycles after the last pixel; pix_ready only while counting, result held until coef_ready.
module dct_coef_mac #(
  parameter int N     = 8,
  parameter int PIX_W = 9,
  parameter int FRAC  = 12,
  parameter int OUT_W = 32
) (
  input logic           clk,
  input logic           rst_n,
  dct_coef_mac_if.slave bus
);
  localparam int KW  = $clog2(N);
  localparam int CW  = FRAC + 2;
  localparam int CCW = 2 * CW;
  localparam int PW  = PIX_W + CW;
  localparam int AW  = PIX_W + 2 * FRAC + 2 * KW + 2;
  localparam int SW  = ((AW > OUT_W) ? AW : OUT_W) + 1;
  localparam int Q   = 28;
  localparam longint PI_Q        = 64'sd843314857;
  localparam longint SQRT_HALF_Q = 64'sd189812531;
  localparam logic [KW-1:0]        NMAX    = KW'(N - 1);
  localparam logic [CCW-1:0]       CC_HALF = CCW'(1) << (FRAC - 1);
  localparam logic [AW-1:0]        A_HALF  = AW'(1) << (FRAC - 1);
  localparam logic signed [SW-1:0] OMAX = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] OMIN = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // cos(m*pi/(2N)) in Q28, folded to the first quadrant and expanded as a Taylor series
  function automatic longint cos_q(input int m);
    int r;
    bit neg;
    longint x, x2, term, sum;
    if (m <= N)          begin r = m;         neg = 1'b0; end
    else if (m <= 2 * N) begin r = 2 * N - m; neg = 1'b1; end
    else if (m <= 3 * N) begin r = m - 2 * N; neg = 1'b1; end
    else                 begin r = 4 * N - m; neg = 1'b0; end
    x    = (longint'(r) * PI_Q) / longint'(2 * N);
    x2   = (x * x) >>> Q;
    term = longint'(1) <<< Q;
    sum  = term;
    for (int i = 0; i < 10; i++) begin
      term = -((term * x2) >>> Q) / longint'((2 * i + 1) * (2 * i + 2));
      sum  = sum + term;
    end
    return neg ? -sum : sum;
  endfunction

  // N is a power of two, so a(k) is a power of two, optionally times sqrt(1/2)
  function automatic longint alpha_q(input int k);
    int e;
    e = (k == 0) ? KW : KW - 1;
    if (e % 2 == 0) return longint'(1) <<< (Q - e / 2);
    return SQRT_HALF_Q >>> ((e - 1) / 2);
  endfunction

  function automatic logic [N*N*CW-1:0] build_rom();
    logic [N*N*CW-1:0] rom;
    longint p, mag, v;
    rom = '0;
    for (int k = 0; k < N; k++) begin
      for (int n = 0; n < N; n++) begin
        p   = cos_q(((2 * n + 1) * k) % (4 * N)) * alpha_q(k);
        mag = (p < 0) ? -p : p;
        v   = (mag + (longint'(1) <<< (2 * Q - FRAC - 1))) >>> (2 * Q - FRAC);
        if (p < 0) v = -v;
        rom[(k * N + n) * CW +: CW] = CW'(v);
      end
    end
    return rom;
  endfunction

  localparam logic [N*N*CW-1:0] ROM = build_rom();

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                  state, state_nxt;
  logic [KW-1:0]           k1_q, k2_q, n1, n2;
  logic                    start_acc, pix_fire;
  logic signed [CW-1:0]    c1, c2, t;
  logic signed [CCW-1:0]   cc;
  logic [CCW-1:0]          cc_mag, t_mag;
  logic signed [PW-1:0]    prod_q;
  logic                    prod_vld;
  logic signed [AW-1:0]    acc;
  logic [AW-1:0]           acc_mag, r_mag;
  logic signed [SW-1:0]    rv;
  logic signed [OUT_W-1:0] coef_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    start_acc     = 1'b0;
    pix_fire      = 1'b0;
    bus.busy      = (state != IDLE);
    bus.pix_ready = 1'b0;
    bus.coef_valid = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        start_acc = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        bus.pix_ready = 1'b1;
        pix_fire      = bus.pix_valid;
        if (bus.pix_valid && n1 == NMAX && n2 == NMAX) state_nxt = FLUSH;
      end
      FLUSH: state_nxt = DONE;
      DONE: begin
        bus.coef_valid = 1'b1;
        if (bus.coef_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Basis term: sign-symmetric rounding of the ROM product
  assign c1 = ROM[int'({k1_q, n1}) * CW +: CW];
  assign c2 = ROM[int'({k2_q, n2}) * CW +: CW];
  assign cc = CCW'(c1) * CCW'(c2);

  always_comb begin
    cc_mag = cc[CCW-1] ? -cc : cc;
    t_mag  = (cc_mag + CC_HALF) >> FRAC;
    t      = cc[CCW-1] ? -CW'(t_mag) : CW'(t_mag);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k1_q     <= '0;
      k2_q     <= '0;
      n1       <= '0;
      n2       <= '0;
      prod_q   <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else begin
      prod_vld <= pix_fire;
      if (pix_fire) prod_q <= PW'(bus.pix_data) * PW'(t);
      if (start_acc) begin
        k1_q <= bus.k1;
        k2_q <= bus.k2;
        n1   <= '0;
        n2   <= '0;
        acc  <= '0;
      end else begin
        if (prod_vld) acc <= acc + AW'(prod_q);
        if (pix_fire) begin
          if (n2 == NMAX) begin
            n2 <= '0;
            n1 <= n1 + 1'b1;
          end else begin
            n2 <= n2 + 1'b1;
          end
        end
      end
    end
  end

  // Final scale: ties away from zero, then clamp into the output range
  always_comb begin
    acc_mag = acc[AW-1] ? -acc : acc;
    r_mag   = (acc_mag + A_HALF) >> FRAC;
    rv      = acc[AW-1] ? -$signed(SW'(r_mag)) : $signed(SW'(r_mag));
    if (rv > OMAX)      coef_sat = OMAX[OUT_W-1:0];
    else if (rv < OMIN) coef_sat = OMIN[OUT_W-1:0];
    else                coef_sat = rv[OUT_W-1:0];
  end

  assign bus.coef_data = (state == DONE) ? coef_sat : '0;
endmodule

// File: tb/tb_dct_coef_mac.sv
// Scoreboard bench for dct_coef_mac: independent real-math model, expected coefficients queued at start.
module tb_dct_coef_mac;
  localparam int  N     = 8;
  localparam int  PIX_W = 9;
  localparam int  FRAC  = 12;
  localparam int  OUT_W = 32;
  localparam int  KW    = $clog2(N);
  localparam int  NPIX  = N * N;
  localparam real PI    = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dct_coef_mac_if #(.N(N), .PIX_W(PIX_W), .OUT_W(OUT_W)) bus ();

  dct_coef_mac #(.N(N), .PIX_W(PIX_W), .FRAC(FRAC), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int     n_checks = 0;
  int     n_pass   = 0;
  longint exp_q[$];
  int     pix[NPIX];
  longint last_coef;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic longint rnd_shift(input longint x, input int sh);
    longint m;
    m = (x < 0) ? -x : x;
    m = (m + (longint'(1) <<< (sh - 1))) >>> sh;
    return (x < 0) ? -m : m;
  endfunction

  function automatic longint rom_c(input int k, input int n);
    real a, v;
    a = (k == 0) ? $sqrt(1.0 / N) : $sqrt(2.0 / N);
    v = a * $cos(real'((2 * n + 1) * k) * PI / real'(2 * N)) * real'(1 << FRAC);
    return (v < 0.0) ? -longint'($floor(-v + 0.5)) : longint'($floor(v + 0.5));
  endfunction

  function automatic longint model(input int k1, input int k2);
    longint acc, r, lim;
    acc = 0;
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++)
        acc += longint'(pix[a * N + b]) * rnd_shift(rom_c(k1, a) * rom_c(k2, b), FRAC);
    r   = rnd_shift(acc, FRAC);
    lim = longint'(1) <<< (OUT_W - 1);
    if (r > lim - 1) r = lim - 1;
    if (r < -lim)    r = -lim;
    return r;
  endfunction

  task automatic begin_block(input int k1, input int k2, input bit push);
    @(negedge clk);
    bus.start = 1'b1;
    bus.k1    = KW'(k1);
    bus.k2    = KW'(k2);
    if (push) exp_q.push_back(model(k1, k2));
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", longint'(bus.busy), 1);
  endtask

  task automatic feed(input int n_stop, input int gap_pct, input bit disturb);
    int i = 0;
    int guard = 0;
    while (i < n_stop && guard < 2000) begin
      bus.pix_valid = ($urandom_range(99) >= gap_pct);
      bus.pix_data  = PIX_W'(pix[i]);
      if (disturb) begin
        bus.k1    = KW'($urandom_range(N - 1));
        bus.k2    = KW'($urandom_range(N - 1));
        bus.start = 1'($urandom_range(1));
      end
      if (bus.pix_valid && bus.pix_ready) i++;
      @(negedge clk);
      guard++;
    end
    bus.pix_valid = 1'b0;
    bus.start     = 1'b0;
    if (guard >= 2000) check("feed_timeout", i, n_stop);
  endtask

  task automatic collect(input string tag, input int hold, input bit start_at_hs);
    int lat = 1;
    longint exp;
    while (!bus.coef_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 2);
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 0, 1);
      return;
    end
    exp = exp_q.pop_front();
    last_coef = longint'(bus.coef_data);
    check({tag, "_coef"}, last_coef, exp);
    for (int h = 0; h < hold; h++) begin
      bus.start     = 1'b1;
      bus.pix_valid = 1'b1;
      bus.k1        = KW'($urandom_range(N - 1));
      @(negedge clk);
      check({tag, "_hold_valid"}, longint'(bus.coef_valid), 1);
      check({tag, "_hold_data"}, longint'(bus.coef_data), exp);
      check({tag, "_hold_pix_ready"}, longint'(bus.pix_ready), 0);
    end
    bus.pix_valid  = 1'b0;
    bus.start      = start_at_hs;
    bus.coef_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_idle_busy"}, longint'(bus.busy), 0);
    check({tag, "_idle_valid"}, longint'(bus.coef_valid), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    real    f;
    longint d;
    bus.start = 1'b0; bus.k1 = '0; bus.k2 = '0;
    bus.pix_valid = 1'b0; bus.pix_data = '0; bus.coef_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_pix_ready", longint'(bus.pix_ready), 0);
    check("rst_coef_valid", longint'(bus.coef_valid), 0);
    check("rst_coef_data", longint'(bus.coef_data), 0);
    rst_n = 1'b1;

    // DC of a flat block
    foreach (pix[i]) pix[i] = 100;
    begin_block(0, 0, 1);
    feed(NPIX, 0, 0);
    collect("dc_flat", 0, 0);
    check("dc_flat_800", last_coef, 800);

    // every AC coefficient of a flat block cancels exactly
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++)
        if (a != 0 || b != 0) begin
          begin_block(a, b, 1);
          feed(NPIX, 0, 0);
          collect("ac_flat", 0, 0);
          check("ac_flat_zero", last_coef, 0);
        end

    // impulse at (2,5) for k=(1,6), also against the unquantised value
    foreach (pix[i]) pix[i] = 0;
    pix[2 * N + 5] = 255;
    begin_block(1, 6, 1);
    feed(NPIX, 0, 0);
    collect("impulse", 0, 0);
    f = 255.0 * $sqrt(2.0 / N) * $cos(5.0 * PI / 16.0) * $sqrt(2.0 / N) * $cos(66.0 * PI / 16.0);
    d = last_coef - longint'($floor(f + 0.5));
    check("impulse_real_within_1", longint'(d <= 1 && d >= -1), 1);

    // random blocks, input gaps, downstream stall with stray start/pix_valid
    for (int r = 0; r < 3; r++) begin
      foreach (pix[i]) pix[i] = int'($urandom_range(511)) - 256;
      bus.coef_ready = 1'b0;
      begin_block(int'($urandom_range(N - 1)), int'($urandom_range(N - 1)), 1);
      feed(NPIX, 30, 0);
      collect("rand_stall", 5, 1);
    end

    // most negative flat block
    foreach (pix[i]) pix[i] = -256;
    begin_block(0, 0, 1);
    feed(NPIX, 0, 0);
    collect("dc_min", 0, 0);
    check("dc_min_value", last_coef, -2048);

    // abort after 30 pixels, then a clean block
    foreach (pix[i]) pix[i] = 100;
    begin_block(0, 0, 0);
    feed(30, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", longint'(bus.busy), 0);
    check("abort_pix_ready", longint'(bus.pix_ready), 0);
    check("abort_coef_valid", longint'(bus.coef_valid), 0);
    rst_n = 1'b1;
    begin_block(0, 0, 1);
    feed(NPIX, 0, 0);
    collect("after_abort", 0, 0);
    check("after_abort_800", last_coef, 800);

    // k and start disturbed during the block
    foreach (pix[i]) pix[i] = int'($urandom_range(511)) - 256;
    begin_block(3, 5, 1);
    feed(NPIX, 20, 1);
    collect("k_latched", 0, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
